// File: rtl/sum_coins.sv
// Coin accumulator: adds one coin per request to a running credit.
// Define SUM_COINS_SAT_EN to saturate the credit instead of wrapping.
module sum_coins #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frt_fg4,
  input  logic              in_RDY4,
  input  logic [DATA_W-1:0] DATA_in4,
  output logic              state_cmp4,
  output logic              out_RDY4,
  output logic [DATA_W-1:0] DATA_out4
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              first_q;
  logic [DATA_W-1:0] coin_q;
  logic [DATA_W-1:0] credit;
  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] sum;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    unique case (state)
      IDLE:    state_nxt = in_RDY4 ? LOAD : IDLE;
      LOAD:    state_nxt = ADD;
      ADD:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A first coin starts from zero credit.
  assign base = first_q ? '0 : credit;

`ifdef SUM_COINS_SAT_EN
  logic [DATA_W:0] sum_ext;

  assign sum_ext = {1'b0, base} + {1'b0, coin_q};
  assign sum     = sum_ext[DATA_W] ? '1 : sum_ext[DATA_W-1:0];
`else
  assign sum = base + coin_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q  <= 1'b0;
      coin_q   <= '0;
      credit   <= '0;
      out_RDY4 <= 1'b0;
    end else begin
      out_RDY4 <= (state == ADD);
      if (state == IDLE && in_RDY4)
        first_q <= frt_fg4;
      if (state == LOAD)
        coin_q <= DATA_in4;
      if (state == ADD)
        credit <= sum;
    end
  end

  assign DATA_out4  = credit;
  assign state_cmp4 = (state == IDLE);

endmodule

// File: tb/tb_sum_coins.sv
// Scoreboard bench for sum_coins: random coins against a credit model.
// Honours SUM_COINS_SAT_EN for the expected overflow behaviour.
module tb_sum_coins;

  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         frt_fg4 = 1'b0;
  logic         in_RDY4 = 1'b0;
  logic [W-1:0] DATA_in4 = '0;
  logic         state_cmp4;
  logic         out_RDY4;
  logic [W-1:0] DATA_out4;

  typedef struct {
    int data;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   credit = 0;
  logic prev_rdy = 1'b0;

  sum_coins #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .frt_fg4    (frt_fg4),
    .in_RDY4    (in_RDY4),
    .DATA_in4   (DATA_in4),
    .state_cmp4 (state_cmp4),
    .out_RDY4   (out_RDY4),
    .DATA_out4  (DATA_out4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic int model(input bit first, input int coin);
    int s;
    s = (first ? 0 : credit) + coin;
`ifdef SUM_COINS_SAT_EN
    if (s > MAX) s = MAX;
`else
    s = s % (MAX + 1);
`endif
    return s;
  endfunction

  // Called #1 after an edge with the DUT idle; returns #1 after
  // the DONE edge so the next request can follow back-to-back.
  task automatic issue(input bit first, input int coin, input bit junk);
    exp_t e;
    in_RDY4 = 1'b1;
    frt_fg4 = first;
    DATA_in4 = W'($urandom);
    @(posedge clk); #1;
    check("busy_load", state_cmp4, 0);
    credit = model(first, coin);
    e.data = credit;
    e.cyc  = cyc + 2;
    sb.push_back(e);
    in_RDY4 = junk ? 1'($urandom) : 1'b0;
    frt_fg4 = junk ? 1'($urandom) : 1'b0;
    DATA_in4 = W'(coin);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("busy", state_cmp4, 0);
      in_RDY4 = junk ? 1'($urandom) : 1'b0;
      frt_fg4 = junk ? 1'($urandom) : 1'b0;
      DATA_in4 = W'($urandom);
    end
    @(posedge clk); #1;
    in_RDY4 = 1'b0;
    frt_fg4 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_RDY4) begin
        exp_t e;
        check("strobe_width", int'(prev_rdy), 0);
        check("strobe_not_idle", state_cmp4, 0);
        if (sb.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          e = sb.pop_front();
          check("data_out", DATA_out4, e.data);
          check("latency", cyc, e.cyc);
        end
      end
      prev_rdy = out_RDY4;
    end else begin
      prev_rdy = 1'b0;
    end
  end

  initial begin
    int gap;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    repeat (3) begin
      @(posedge clk); #1;
      check("rst_idle", state_cmp4, 1);
      check("rst_rdy", out_RDY4, 0);
      check("rst_data", DATA_out4, 0);
    end

    issue(1'b1, 1, 1'b0);
    issue(1'b0, 5, 1'b0);
    issue(1'b1, 10, 1'b1);
    issue(1'b1, 250, 1'b1);
    issue(1'b0, 10, 1'b0);
    issue(1'b0, 0, 1'b1);
    check("hold_data", DATA_out4, credit);

    // Abandon a transaction while in ADD.
    in_RDY4 = 1'b1;
    frt_fg4 = 1'b0;
    @(posedge clk); #1;
    in_RDY4 = 1'b0;
    DATA_in4 = 8'd77;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_idle", state_cmp4, 1);
    check("midrst_rdy", out_RDY4, 0);
    check("midrst_data", DATA_out4, 0);
    rst = 1'b0;
    credit = 0;
    repeat (3) @(posedge clk);
    #1;

    issue(1'b0, 200, 1'b0);
    issue(1'b0, 100, 1'b0);

    for (int i = 0; i < 40; i++) begin
      issue(($urandom_range(3) == 0), $urandom_range(MAX),
            1'($urandom));
      gap = $urandom_range(2);
      if (gap != 0) begin
        repeat (gap) @(posedge clk);
        #1;
        check("gap_idle", state_cmp4, 1);
      end
    end

    for (int t = 0; t < 20 && sb.size() != 0; t++)
      @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
